range_stream_driver: RTL
========================

// Module: range_stream_driver
// PURPOSE
//  Initiator side of the range-finder streaming interface: generates a word stream
//  (ramp or LFSR) framed by go/finish and tracks its own min/max, then samples the
//  finder's range/error response and reports pass/fail. Used as on-chip self-test.
// PARAMETERS
//  WIDTH     10      data word width; also the width of range_in and expected
//  LENW      5       length field width; supported stream length 2..2**LENW-1 words
//  RESP_LAT  1       cycles from the finish beat to the range_in sample point (>=1)
//  TAPS      10'h204 Galois LFSR feedback mask (WIDTH bits)
// PORTS
//  clock      in   1      system clock, all state on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      begin a run; sampled only in IDLE
//  len        in   LENW   number of words in the stream; sampled with start
//  seed       in   WIDTH  first word; sampled with start
//  ramp       in   1      1 = word i is seed+i (mod 2**WIDTH); 0 = LFSR sequence
//  range_in   in   WIDTH  range result returned by the finder
//  error_in   in   1      finder error flag
//  data_out   out  WIDTH  stream word, valid while go or STREAM is active
//  go         out  1      high on the first word only
//  finish     out  1      high on the last word only
//  busy       out  1      high in STREAM, WAIT and CHECK
//  done       out  1      one-cycle pulse at end of run
//  pass       out  1      result of the last run; held until the next done
//  len_err    out  1      last start had len<2; held until the next done
//  expected   out  WIDTH  max-min of the words sent in the last run
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; min/max/counters cleared. Reset mid-stream
//    drops go/finish/data_out immediately; no done is produced for the aborted run.
//  - All outputs are registered. FSM: IDLE -> STREAM -> WAIT -> CHECK -> IDLE.
//  - IDLE: start=1 and len>=2 -> latch len/seed/ramp, enter STREAM next cycle.
//    start=1 and len<2 -> no stream; next cycle done=1, pass=0, len_err=1,
//    expected=0. start outside IDLE is ignored (no queueing).
//  - STREAM: exactly one word per cycle for len cycles. Beat 0: go=1, data_out=seed.
//    Beat len-1: finish=1. go and finish never coincide because len>=2.
//  - Ramp mode: data_out = seed+i, truncated to WIDTH (wraps 2**WIDTH-1 -> 0).
//  - LFSR mode: seed 0 is replaced by 1. Next = (s>>1) ^ (s[0] ? TAPS : 0).
//  - min/max initialise from beat 0 and update on every beat, so expected covers
//    every transmitted word. expected = max-min as unsigned and is updated in CHECK.
//  - WAIT: RESP_LAT-1 cycles with data_out=0 and go=finish=0.
//    CHECK (RESP_LAT cycles after finish): sample range_in and error_in.
//    pass = (range_in==expected) && !error_in; len_err=0; done=1 for one cycle.
//  - Return to IDLE on the cycle after CHECK. start may be accepted on that IDLE cycle,
//    so back-to-back runs are separated by one idle cycle.
//  - Outside STREAM: data_out=0.
// TESTING
//  1 reset_n low mid-stream, e.g. on beat 3 -> all outputs 0 at once.
//    After release: IDLE, no done; a new start then runs normally.
//  2 ramp=1 seed=100 len=5; model returns range 4 -> go with word 100.
//    Words 100..104 follow; finish with 104; done, pass=1, expected=4.
//  3 ramp=1 seed=1022 len=4 -> words 1022,1023,0,1. expected=1023.
//    Return range 1023 -> pass=1; return 1022 -> pass=0.
//  4 ramp=0 seed=0 len=3 -> first word is 1, then LFSR sequence per TAPS.
//    expected matches the reference model; error_in=1 at CHECK -> pass=0.
//  5 len=1 and len=0 -> no go/finish; done 1 cycle after start, pass=0, len_err=1.
//  6 start held high continuously, len=2 -> runs repeat with one idle cycle between.
//    start is ignored while busy; RESP_LAT=3 variant samples range_in 3 cycles after finish.

Source files
------------

// File: rtl/range_stream_driver_if.sv
// range_stream_driver_if
//  Groups the request, stream and response signals between the range-finder
//  self-test driver and the logic around it.
//  master : the driver (range_stream_driver)
//           in  start, len, seed, ramp, range_in, error_in
//           out data_out, go, finish, busy, done, pass, len_err, expected
//  slave  : the controller/finder side, directions mirrored
interface range_stream_driver_if #(
  parameter int WIDTH = 10,
  parameter int LENW  = 5
);
  logic             start;
  logic [LENW-1:0]  len;
  logic [WIDTH-1:0] seed;
  logic             ramp;
  logic [WIDTH-1:0] range_in;
  logic             error_in;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             done;
  logic             pass;
  logic             len_err;
  logic [WIDTH-1:0] expected;

  modport master (
    input  start, len, seed, ramp, range_in, error_in,
    output data_out, go, finish, busy, done, pass, len_err, expected
  );

  modport slave (
    output start, len, seed, ramp, range_in, error_in,
    input  data_out, go, finish, busy, done, pass, len_err, expected
  );
endinterface

// File: rtl/range_stream_driver.sv
// range_stream_driver
//  Initiator side of the range-finder stream. On start it emits len words
//  (ramp or Galois LFSR) framed by go/finish, tracks the min/max of what it
//  sent, then RESP_LAT cycles after the finish beat samples the finder's
//  range/error response and reports pass/fail with a one-cycle done.
//  Ports:
//    clock    system clock, rising edge
//    reset_n  asynchronous active-low reset
//    bus      range_stream_driver_if.master (request, stream, response, status)
//  All outputs come straight from flops.
module range_stream_driver #(
  parameter int               WIDTH    = 10,
  parameter int               LENW     = 5,
  parameter int               RESP_LAT = 1,
  parameter logic [WIDTH-1:0] TAPS     = 10'h204
) (
  input  logic                  clock,
  input  logic                  reset_n,
  range_stream_driver_if.master bus
);

  // state    | meaning
  // S_IDLE   | waiting for start; len<2 requests complete directly from here
  // S_STREAM | one word per cycle; go on the first beat, finish on the last
  // S_WAIT   | RESP_LAT-1 quiet cycles while the finder works
  // S_CHECK  | sample range_in/error_in, publish pass/expected, raise done
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  // Wait timer is a down-counter; it only exists in a meaningful form for
  // RESP_LAT >= 2 (RESP_LAT == 1 goes from the finish beat straight to CHECK).
  localparam int WAITW = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;
  localparam logic [WAITW-1:0] WAIT_LOAD = (RESP_LAT > 2) ? WAITW'(RESP_LAT - 2) : '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [LENW-1:0]  beat_q, beat_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic             ramp_q, ramp_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             len_err_q, len_err_d;
  logic [WIDTH-1:0] expected_q, expected_d;

  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] span;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
  assign seed_eff  = (!bus.ramp && (bus.seed == '0)) ? WIDTH'(1) : bus.seed;
  // data_q holds the word currently on the bus while streaming.
  assign next_word = ramp_q ? (data_q + WIDTH'(1)) : lfsr_next(data_q);
  assign span      = max_q - min_q;

  always_comb begin
    state_d    = state_q;
    data_d     = '0;
    min_d      = min_q;
    max_d      = max_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    ramp_d     = ramp_q;
    go_d       = 1'b0;
    finish_d   = 1'b0;
    done_d     = 1'b0;
    pass_d     = pass_q;
    len_err_d  = len_err_q;
    expected_d = expected_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len >= LENW'(2)) begin
            state_d = S_STREAM;
            data_d  = seed_eff;
            go_d    = 1'b1;
            min_d   = seed_eff;
            max_d   = seed_eff;
            // beats still to send after the one going out now
            beat_d  = bus.len - LENW'(1);
            ramp_d  = bus.ramp;
          end else begin
            done_d     = 1'b1;
            pass_d     = 1'b0;
            len_err_d  = 1'b1;
            expected_d = '0;
          end
        end
      end

      S_STREAM: begin
        if (beat_q == '0) begin
          state_d = (RESP_LAT == 1) ? S_CHECK : S_WAIT;
          wait_d  = WAIT_LOAD;
        end else begin
          data_d   = next_word;
          beat_d   = beat_q - LENW'(1);
          finish_d = (beat_q == LENW'(1));
          if (next_word < min_q) min_d = next_word;
          if (next_word > max_q) max_d = next_word;
        end
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - WAITW'(1);
        end
      end

      S_CHECK: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        expected_d = span;
        pass_d     = (bus.range_in == span) && !bus.error_in;
        len_err_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      ramp_q     <= 1'b0;
      go_q       <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      len_err_q  <= 1'b0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      min_q      <= min_d;
      max_q      <= max_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      ramp_q     <= ramp_d;
      go_q       <= go_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      len_err_q  <= len_err_d;
      expected_q <= expected_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.go       = go_q;
  assign bus.finish   = finish_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.len_err  = len_err_q;
  assign bus.expected = expected_q;

endmodule
